pipe_stage_elastic: RTL and testbench
=====================================

Name: pipe_stage_elastic

Overview:
- Parametrised successor to the fixed enable-gated inter-stage registers (if/id, id/ex, ex/mem, mem/wb).
- Implements a DEPTH-stage elastic pipeline register of WIDTH bits with per-stage valid bits and valid/ready handshakes at both ends.
- Provides bubble collapsing, synchronous flush to a programmable NOP value, and an occupancy count.
- Used between CPU stages and cache/memory paths where back-pressure replaces a global enable.

Parameters:
- WIDTH, 32, payload width in bits (≥1).
- DEPTH, 1, number of register stages (1..8).
- RESET_VAL, 0, WIDTH-bit payload value loaded at reset and on flush (e.g. a NOP/ADDI encoding).

Ports:
- CLK  input  1  clock, rising edge.
- nRST  input  1  asynchronous reset, active-low.
- flush  input  1  synchronous flush; clears all stages.
- in_valid  input  1  upstream has payload.
- in_ready  output  1  block accepts payload this cycle.
- in_data  input  WIDTH  upstream payload.
- out_valid  output  1  payload available at output.
- out_ready  input  1  downstream accepts payload.
- out_data  output  WIDTH  payload of last stage.
- count  output  $clog2(DEPTH+1)  number of valid stages.

Behaviour:
- Reset: the block has stages s[0..DEPTH-1]; s[DEPTH-1] drives out_data. Asynchronous reset (nRST low) clears every valid[i] and loads every data[i] with RESET_VAL. While in reset: out_valid=0, out_data=RESET_VAL, count=0, in_ready=0.
- Move rule (combinational):
  - mv[last] = valid[last] & out_ready & !flush.
  - mv[i] = valid[i] & (!valid[i+1] | mv[i+1]) & !flush.
- Input acceptance: in_ready = (!valid[0] | mv[0]) & !flush.
- Stage 0 loads in_data and sets valid[0] when in_valid & in_ready. Otherwise valid[0] clears if mv[0], else holds.
- Stage i>0 loads data[i-1] and sets valid[i] when mv[i-1]. Otherwise valid[i] clears if mv[i], else holds.
- Bubble collapse: an empty stage accepts from its predecessor even when downstream is stalled. With DEPTH stages full and out_ready=0, in_ready=0.
- Data of an invalid stage holds its last value; there are no speculative loads.
- Output: out_valid = valid[last] & !flush. out_data = data[last].
- Once out_valid=1 and out_ready=0, out_data and out_valid stay stable until the transfer or a flush.
- Latency: a payload accepted at edge t appears at out_valid at edge t+DEPTH-1, i.e. it is visible the cycle after edge t+DEPTH-1. With out_ready held at 1, throughput is 1 per cycle.
- Flush has priority over all traffic:
  - On the edge with flush=1, all valid clear and all data load RESET_VAL.
  - in_data presented that cycle is dropped (in_ready=0).
  - No output transfer occurs that cycle (out_valid masked).
- Simultaneous accept and emit when full: allowed. With out_ready=1 and in_valid=1, occupancy is unchanged and the chain shifts one stage.
- count = popcount(valid), registered-state based. Range 0..DEPTH.
- Reset mid-operation: an asynchronous reset discards all in-flight payloads immediately, with no partial output.

Optional Feature:
- Macro: PIPE_STAGE_STALL_CNT_EN.
- When defined:
  - Adds output port stall_cycles, 32 bits.
  - The counter increments on every cycle with valid[last]=1, out_ready=0 and flush=0.
  - It saturates at 32'hFFFFFFFF.
  - It is cleared only by nRST (not by flush).
- When undefined: the port and counter are absent, and behaviour is otherwise identical.

Test Plan:
- Reset: DEPTH=3, RESET_VAL=32'h20000000, hold nRST low for 2 cycles → out_valid=0, out_data=32'h20000000, count=0, in_ready=0. After release → in_ready=1.
- Streaming: DEPTH=3, out_ready=1, inputs 1,2,3,4 on consecutive cycles → out_data 1,2,3,4 on consecutive cycles, with first out_valid 3 cycles after the first accept and count steady at 3.
- Back-pressure and collapse: DEPTH=3, out_ready=0, feed A,B,C,D → A,B,C accepted, count=3, in_ready=0 while D is held. Release out_ready for 1 cycle → A emitted and D accepted on the same edge, count stays 3.
- Bubble: DEPTH=3, feed A, 2 idle cycles, then B, with out_ready=0 → A and B occupy s[2] and s[1], count=2, in_ready=1.
- Flush: DEPTH=2, pipeline full, flush=1 with in_valid=1, out_ready=1 → no output transfer and input dropped. Next cycle: count=0, out_valid=0, out_data=RESET_VAL.
- Stall counter (PIPE_STAGE_STALL_CNT_EN): hold a valid output with out_ready=0 for 5 cycles → stall_cycles=5. A flush leaves it at 5; nRST clears it to 0.

Source files
------------

// File: rtl/pipe_stage_elastic.sv
// rtl/pipe_stage_elastic.sv - DEPTH-stage elastic pipeline register with valid/ready, flush and occupancy
// Optional stall counter on output back-pressure: define PIPE_STAGE_STALL_CNT_EN.
module pipe_stage_elastic #(
  parameter int               WIDTH     = 32,
  parameter int               DEPTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                       CLK,
  input  logic                       nRST,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(DEPTH+1)-1:0] count
`ifdef PIPE_STAGE_STALL_CNT_EN
  ,
  output logic [31:0]                stall_cycles
`endif
);

  localparam int LAST = DEPTH - 1;
  localparam int CW   = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] valid;
  logic [WIDTH-1:0] data [DEPTH];
  logic [DEPTH-1:0] mv;
  logic             load0;

  // A stage advances when its successor is empty or itself advancing; flush freezes all motion.
  always_comb begin
    mv       = '0;
    mv[LAST] = valid[LAST] & out_ready & ~flush;
    for (int i = DEPTH - 2; i >= 0; i--) begin
      mv[i] = valid[i] & (~valid[i+1] | mv[i+1]) & ~flush;
    end
  end

  assign in_ready  = (~valid[0] | mv[0]) & ~flush & nRST;
  assign load0     = in_valid & in_ready;
  assign out_valid = valid[LAST] & ~flush;
  assign out_data  = data[LAST];

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      valid <= '0;
      for (int i = 0; i < DEPTH; i++) data[i] <= RESET_VAL;
    end else if (flush) begin
      valid <= '0;
      for (int i = 0; i < DEPTH; i++) data[i] <= RESET_VAL;
    end else begin
      if (load0) begin
        data[0]  <= in_data;
        valid[0] <= 1'b1;
      end else if (mv[0]) begin
        valid[0] <= 1'b0;
      end
      for (int i = 1; i < DEPTH; i++) begin
        if (mv[i-1]) begin
          data[i]  <= data[i-1];
          valid[i] <= 1'b1;
        end else if (mv[i]) begin
          valid[i] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    count = '0;
    for (int i = 0; i < DEPTH; i++) begin
      count = count + CW'(valid[i]);
    end
  end

`ifdef PIPE_STAGE_STALL_CNT_EN
  // Survives flush on purpose: it measures back-pressure over the whole run.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stall_cycles <= '0;
    end else if (valid[LAST] && !out_ready && !flush && stall_cycles != 32'hFFFF_FFFF) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// tb/tb_pipe_stage_elastic.sv - scoreboard bench for pipe_stage_elastic (DEPTH=3 and DEPTH=2 instances)
module tb_pipe_stage_elastic;

  localparam logic [31:0] RV_A = 32'h2000_0000;
  localparam logic [31:0] RV_B = 32'h0000_0013;

  logic        CLK = 1'b0;
  logic        nRST;
  always #5 CLK = ~CLK;

  logic        a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [31:0] a_in_data, a_out_data;
  logic [1:0]  a_count;
  logic        b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [31:0] b_in_data, b_out_data;
  logic [1:0]  b_count;
`ifdef PIPE_STAGE_STALL_CNT_EN
  logic [31:0] a_stall, b_stall;
`endif

  pipe_stage_elastic #(.WIDTH(32), .DEPTH(3), .RESET_VAL(RV_A)) u_a (
    .CLK(CLK), .nRST(nRST), .flush(a_flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .count(a_count)
`ifdef PIPE_STAGE_STALL_CNT_EN
    , .stall_cycles(a_stall)
`endif
  );

  pipe_stage_elastic #(.WIDTH(32), .DEPTH(2), .RESET_VAL(RV_B)) u_b (
    .CLK(CLK), .nRST(nRST), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .count(b_count)
`ifdef PIPE_STAGE_STALL_CNT_EN
    , .stall_cycles(b_stall)
`endif
  );

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic        acc, emit;
  logic [31:0] sb [$];
  logic [31:0] exp_d;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Sample handshakes before the edge: accepted payloads are pushed, emitted payloads popped and compared.
  task automatic tick();
    #1;
    acc  = a_in_valid & a_in_ready;
    emit = a_out_valid & a_out_ready;
    if (acc) sb.push_back(a_in_data);
    if (emit) begin
      if (sb.size() == 0) check("sb_underflow", 1, 0);
      else begin
        exp_d = sb.pop_front();
        check("sb_data", a_out_data, exp_d);
      end
    end
    @(posedge CLK);
    @(negedge CLK);
    cyc++;
  endtask

  task automatic b_edge();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  int          first_acc, first_emit, idx;
  logic [31:0] bp [4];

  initial begin
    bp = '{32'hA0, 32'hB0, 32'hC0, 32'hD0};
    nRST = 1'b0;
    a_flush = 0; a_in_valid = 0; a_in_data = 0; a_out_ready = 0;
    b_flush = 0; b_in_valid = 0; b_in_data = 0; b_out_ready = 0;

    @(negedge CLK);
    @(negedge CLK);
    #1;
    check("rst_out_valid", a_out_valid, 0);
    check("rst_out_data", a_out_data, RV_A);
    check("rst_count", a_count, 0);
    check("rst_in_ready", a_in_ready, 0);
    check("rst_b_out_data", b_out_data, RV_B);
    @(negedge CLK);
    nRST = 1'b1;
    #1;
    check("rst_rel_in_ready", a_in_ready, 1);
    @(negedge CLK);

    // Streaming at full rate
    a_out_ready = 1;
    first_acc = -1;
    first_emit = -1;
    for (int i = 0; i < 8; i++) begin
      a_in_valid = (i < 4);
      a_in_data  = 32'(i + 1);
      #1;
      if (i == 3 || i == 4) check("stream_count", a_count, 3);
      if (a_out_valid && first_emit < 0) first_emit = cyc;
      if (a_in_valid && a_in_ready && first_acc < 0) first_acc = cyc;
      tick();
    end
    a_in_valid = 0;
    check("stream_latency", 64'(first_emit - first_acc), 3);
    check("stream_drained", sb.size(), 0);

    // Back-pressure: three fill, the fourth waits
    a_out_ready = 0;
    idx = 0;
    for (int i = 0; i < 5; i++) begin
      a_in_valid = 1;
      a_in_data  = bp[idx];
      tick();
      if (acc && idx < 3) idx++;
    end
    #1;
    check("bp_accepts", idx, 3);
    check("bp_count", a_count, 3);
    check("bp_in_ready", a_in_ready, 0);
    check("bp_out_valid", a_out_valid, 1);
    check("bp_out_hold", a_out_data, 32'hA0);
    a_out_ready = 1;
    #1;
    check("bp_shift_ready", a_in_ready, 1);
    tick();
    check("bp_d_accepted", acc, 1);
    a_out_ready = 0;
    a_in_valid = 0;
    #1;
    check("bp_count_after", a_count, 3);
    check("bp_next_out", a_out_data, 32'hB0);
    a_out_ready = 1;
    for (int i = 0; i < 5; i++) tick();
    check("bp_drained", sb.size(), 0);

    // Bubble collapse under stall
    a_out_ready = 0;
    a_in_valid = 1; a_in_data = 32'hC1; tick();
    a_in_valid = 0; tick(); tick();
    a_in_valid = 1; a_in_data = 32'hC2; tick();
    a_in_valid = 0; tick();
    #1;
    check("bub_count", a_count, 2);
    check("bub_in_ready", a_in_ready, 1);
    check("bub_out_data", a_out_data, 32'hC1);
    a_out_ready = 1;
    for (int i = 0; i < 4; i++) tick();
    check("bub_drained", sb.size(), 0);

    // Flush on the DEPTH=2 instance
    b_in_valid = 1; b_in_data = 32'hB1; b_edge();
    b_in_data = 32'hB2; b_edge();
    b_in_valid = 0;
    #1;
    check("fl_full", b_count, 2);
    b_flush = 1; b_in_valid = 1; b_in_data = 32'hB3; b_out_ready = 1;
    #1;
    check("fl_out_masked", b_out_valid, 0);
    check("fl_in_dropped", b_in_ready, 0);
    b_edge();
    b_flush = 0; b_in_valid = 0;
    #1;
    check("fl_count", b_count, 0);
    check("fl_out_valid", b_out_valid, 0);
    check("fl_out_data", b_out_data, RV_B);
    b_in_valid = 1; b_in_data = 32'hB4; b_edge();
    b_in_valid = 0; b_edge();
    #1;
    check("fl_after_valid", b_out_valid, 1);
    check("fl_after_data", b_out_data, 32'hB4);
    b_edge();

    // Asynchronous reset mid-operation
    a_out_ready = 0;
    a_in_valid = 1; a_in_data = 32'hE1; tick();
    a_in_data = 32'hE2; tick(); tick();
    a_in_valid = 0;
    #2;
    nRST = 1'b0;
    #1;
    check("amid_out_valid", a_out_valid, 0);
    check("amid_count", a_count, 0);
    check("amid_out_data", a_out_data, RV_A);
    sb.delete();
    @(negedge CLK);
    nRST = 1'b1;
    @(negedge CLK);

`ifdef PIPE_STAGE_STALL_CNT_EN
    a_out_ready = 0;
    a_in_valid = 1; a_in_data = 32'hF1; tick();
    a_in_valid = 0;
    for (int i = 0; i < 10 && !a_out_valid; i++) tick();
    check("st_reach_out", a_out_valid, 1);
    check("st_zero", a_stall, 0);
    for (int i = 0; i < 5; i++) tick();
    check("st_five", a_stall, 5);
    a_flush = 1; tick();
    a_flush = 0;
    sb.delete();
    check("st_flush_keeps", a_stall, 5);
    nRST = 1'b0;
    #1;
    check("st_rst_clears", a_stall, 0);
    @(negedge CLK);
    nRST = 1'b1;
    @(negedge CLK);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
